// File: rtl/inst_fetch_pkg.sv
`ifndef BITTY_DEFS_V
`include "bitty_defs.sv"
`endif
// ============================================================================
//  inst_fetch_pkg
//  Types and helpers shared by the instruction fetch unit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

   // One instruction buffer entry: the word and the address it came from.
   typedef struct packed {
      logic [`InstAddrBus] pc;
      logic [`InstBus]     inst;
   } fetch_entry_t;

   // Width of a counter that must hold the values 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bitty_defs.sv
// ============================================================================
//  bitty_defs
//  Shared Bitty core bus widths and instruction constants.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`ifndef BITTY_DEFS_V
`define BITTY_DEFS_V

`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h00000000
`define NopInst     32'h00000013

`endif
`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  sync_fifo
//  Single-clock FIFO with synchronous clear; push and pop may coincide,
//  including at full. Storage is not reset.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_clr,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_din,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_dout,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_push;
   logic               w_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
      return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
   endfunction

   assign o_full  = (r_count == c_cnt_w'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign w_push = i_push & (~o_full | i_pop);
   assign w_pop  = i_pop & ~o_empty;

   // Pointer and occupancy bookkeeping; clear wins over any push or pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
      end
   end

   // Data storage write; left out of reset on purpose.
   always_ff @(posedge clk) begin
      if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
`ifndef BITTY_DEFS_V
`include "bitty_defs.sv"
`endif
// ============================================================================
//  inst_fetch
//  Credit-limited instruction fetch: issues in-order memory requests, keeps
//  their addresses, buffers returned words for decode, and discards the
//  responses of requests orphaned by a redirect.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [`InstAddrBus] pc_i,
   input  logic                ce_i,
   output logic                pc_ready_o,
   output logic                imem_req_o,
   output logic [`InstAddrBus] imem_addr_o,
   input  logic                imem_gnt_i,
   input  logic                imem_rvalid_i,
   input  logic [`InstBus]     imem_rdata_i,
   input  logic                flush_i,
   output logic                id_valid_o,
   input  logic                id_ready_i,
   output logic [`InstBus]     id_inst_o,
   output logic [`InstAddrBus] id_pc_o
);

   localparam int c_cnt_w = cnt_width(DEPTH);
   localparam int c_sum_w = c_cnt_w + 2;

   logic [c_cnt_w-1:0]  w_outstanding;
   logic [c_cnt_w-1:0]  w_occupancy;
   logic [c_cnt_w-1:0]  r_drop_cnt;
   logic [c_cnt_w:0]    w_pending;
   logic [c_sum_w-1:0]  w_inflight;
   logic                w_aq_full;
   logic                w_aq_empty;
   logic                w_buf_full;
   logic                w_buf_empty;
   logic [`InstAddrBus] w_aq_head;
   fetch_entry_t        w_buf_in;
   fetch_entry_t        w_buf_head;
   logic                w_credit;
   logic                w_req;
   logic                w_grant;
   logic                w_drop;
   logic                w_rv_keep;
   logic                w_id_pop;

   // Everything that will eventually occupy a buffer slot: live requests,
   // orphaned requests still to return, and words already buffered. The
   // full flags are redundant with the sum but keep the queues safe by
   // construction.
   assign w_inflight = c_sum_w'(w_outstanding) + c_sum_w'(r_drop_cnt) + c_sum_w'(w_occupancy);
   assign w_credit   = (w_inflight < c_sum_w'(DEPTH)) & ~w_aq_full & ~w_buf_full;

   assign w_req       = ce_i & ~flush_i & w_credit;
   assign w_grant     = w_req & imem_gnt_i;
   assign imem_req_o  = w_req;
   assign imem_addr_o = pc_i;
   assign pc_ready_o  = w_grant;

   // Responses owed to a pre-redirect request are swallowed; a response with
   // nothing outstanding is ignored rather than corrupting the queues.
   assign w_drop    = imem_rvalid_i & (r_drop_cnt != '0);
   assign w_rv_keep = imem_rvalid_i & ~w_drop & ~w_aq_empty;

   assign w_buf_in.pc   = w_aq_head;
   assign w_buf_in.inst = imem_rdata_i;

   assign id_valid_o = ~w_buf_empty & ~flush_i;
   assign w_id_pop   = id_valid_o & id_ready_i;
   assign id_inst_o  = w_buf_empty ? `NopInst  : w_buf_head.inst;
   assign id_pc_o    = w_buf_empty ? `ZeroWord : w_buf_head.pc;

   // Live request count and orphan count together, as seen in a flush cycle.
   assign w_pending = (c_cnt_w + 1)'(w_outstanding) + (c_cnt_w + 1)'(r_drop_cnt);

   // Orphan counter: a redirect turns every live request into an orphan,
   // less the one answered in the redirect cycle itself.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_drop_cnt <= '0;
      end else if (flush_i) begin
         r_drop_cnt <= c_cnt_w'((imem_rvalid_i && (w_pending != '0))
                                ? w_pending - (c_cnt_w + 1)'(1) : w_pending);
      end else if (w_drop) begin
         r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
      end
   end

   // Addresses of granted requests; its occupancy is the outstanding count.
   sync_fifo #(
      .WIDTH ($bits(w_aq_head)),
      .DEPTH (DEPTH)
   ) u_addr_q (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (flush_i),
      .i_push  (w_grant),
      .i_din   (pc_i),
      .i_pop   (w_rv_keep),
      .o_dout  (w_aq_head),
      .o_full  (w_aq_full),
      .o_empty (w_aq_empty),
      .o_count (w_outstanding)
   );

   // Returned words waiting for decode; registered, so one cycle of latency.
   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_inst_buf (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (flush_i),
      .i_push  (w_rv_keep),
      .i_din   (w_buf_in),
      .i_pop   (w_id_pop),
      .o_dout  (w_buf_head),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty),
      .o_count (w_occupancy)
   );

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
//  tb_inst_fetch
//  Randomised bench for inst_fetch against a queue-based reference model of
//  the memory, the PC stage and the expected decode stream.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] c_nop    = 32'h00000013;
   localparam int          c_cycles = 4000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic        pc_ready_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        flush_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_inst_o;
   logic [31:0] id_pc_o;

   always #5 clk = ~clk;

   inst_fetch #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .ce_i          (ce_i),
      .pc_ready_o    (pc_ready_o),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .flush_i       (flush_i),
      .id_valid_o    (id_valid_o),
      .id_ready_i    (id_ready_i),
      .id_inst_o     (id_inst_o),
      .id_pc_o       (id_pc_o)
   );

   // Memory request awaiting its response; epoch marks the redirect it belongs to.
   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   mreq_t mem_q[$];
   ent_t  exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic bit chance(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   initial begin
      logic [31:0] pc;
      int          epoch;
      int          p_ce, p_gnt, p_rdy, p_flush, p_rst, max_delay;
      bit          exp_req, exp_valid;
      mreq_t       h;

      rst = 1'b0; ce_i = 1'b0; pc_i = '0; flush_i = 1'b0; imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b0;
      pc = '0;
      epoch = 0;
      repeat (2) @(posedge clk);

      for (int cyc = 0; cyc < c_cycles; cyc++) begin
         @(negedge clk);

         // Phases: streaming, decode backpressure, fetch idle, then random mix.
         if (cyc < 150) begin
            p_ce = 100; p_gnt = 100; p_rdy = 100; p_flush = 0; p_rst = 0; max_delay = 1;
         end else if (cyc < 300) begin
            p_ce = 100; p_gnt = 100; p_rdy = ((cyc % 40) >= 34) ? 100 : 0;
            p_flush = 0; p_rst = 0; max_delay = 1;
         end else if (cyc < 340) begin
            p_ce = 0; p_gnt = 100; p_rdy = 100; p_flush = 0; p_rst = 0; max_delay = 2;
         end else if (cyc < 1500) begin
            p_ce = 90; p_gnt = 80; p_rdy = 80; p_flush = 5; p_rst = 0; max_delay = 3;
         end else begin
            p_ce = 80; p_gnt = 60; p_rdy = 60; p_flush = 6; p_rst = 1; max_delay = 4;
         end

         rst        = chance(p_rst) ? 1'b0 : 1'b1;
         ce_i       = chance(p_ce);
         pc_i       = ce_i ? pc : $urandom;
         flush_i    = chance(p_flush);
         imem_gnt_i = chance(p_gnt);
         id_ready_i = chance(p_rdy);
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
         end
         #1;

         exp_req   = ce_i && !flush_i && (mem_q.size() + exp_q.size() < DEPTH);
         exp_valid = (exp_q.size() > 0) && !flush_i;
         check_val("imem_req",  {31'b0, imem_req_o}, {31'b0, exp_req});
         check_val("imem_addr", imem_addr_o, pc_i);
         check_val("pc_ready",  {31'b0, pc_ready_o}, {31'b0, exp_req && imem_gnt_i});
         check_val("id_valid",  {31'b0, id_valid_o}, {31'b0, exp_valid});
         if (exp_q.size() > 0) begin
            check_val("id_pc",   id_pc_o,   exp_q[0].pc);
            check_val("id_inst", id_inst_o, exp_q[0].inst);
         end else begin
            check_val("id_pc_empty",   id_pc_o,   32'h0);
            check_val("id_inst_empty", id_inst_o, c_nop);
         end

         // Advance the reference model across the coming clock edge.
         if (!rst) begin
            mem_q.delete();
            exp_q.delete();
            epoch++;
            pc = '0;
         end else begin
            if (exp_valid && id_ready_i) void'(exp_q.pop_front());
            if (imem_rvalid_i) begin
               h = mem_q.pop_front();
               if (h.epoch == epoch && !flush_i)
                  exp_q.push_back('{pc: h.addr, inst: mem_word(h.addr)});
            end
            if (flush_i) begin
               exp_q.delete();
               epoch++;
               pc = 32'h40 + ($urandom_range(0, 15) << 4);
            end else if (exp_req && imem_gnt_i) begin
               mem_q.push_back('{addr: pc, due: cyc + $urandom_range(1, max_delay), epoch: epoch});
               pc = pc + 32'h1;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
